// File: rtl/probe_window_if.sv
// CPU-side control and result bus of the logic-probe measurement window sequencer.
// The master drives requests and acknowledges; the slave (sequencer) returns DAC codes and results.
interface probe_window_if #(
    parameter int COUNTER_BITS = 24
) ();
    logic                    start;
    logic                    continuous;
    logic [4:0]              dac1_code_in;
    logic [4:0]              dac2_code_in;
    logic [4:0]              dac1_code;
    logic [4:0]              dac2_code;
    logic                    busy;
    logic                    result_valid;
    logic                    result_ack;
    logic                    overrun;
    logic [COUNTER_BITS-1:0] count_hi;
    logic [COUNTER_BITS-1:0] count_lo;
    logic [COUNTER_BITS-1:0] count_z;
    logic [COUNTER_BITS-1:0] count_edges;

    modport master (
        output start, continuous, dac1_code_in, dac2_code_in, result_ack,
        input  dac1_code, dac2_code, busy, result_valid, overrun,
        input  count_hi, count_lo, count_z, count_edges
    );

    modport slave (
        input  start, continuous, dac1_code_in, dac2_code_in, result_ack,
        output dac1_code, dac2_code, busy, result_valid, overrun,
        output count_hi, count_lo, count_z, count_edges
    );
endinterface

// File: rtl/probe_window_ctrl.sv
// Measurement-window sequencer: sets DAC thresholds, waits for settling, then classifies
// synchronized comparator samples (hi/lo/Z) and rising edges over a fixed window.
module probe_window_ctrl #(
    parameter int PERIOD        = 12000000,
    parameter int COUNTER_BITS  = 24,
    parameter int SETTLE_CYCLES = 16,
    parameter int SETTLE_BITS   = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            comp_out_hi,
    input  logic            comp_out_lo,
    probe_window_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [COUNTER_BITS-1:0] WIN_LAST    = COUNTER_BITS'(PERIOD - 1);
    localparam logic [COUNTER_BITS-1:0] CNT_ZERO    = {COUNTER_BITS{1'b0}};
    localparam logic [COUNTER_BITS-1:0] CNT_ONE     = COUNTER_BITS'(1);
    localparam logic [COUNTER_BITS-1:0] CNT_MAX     = {COUNTER_BITS{1'b1}};
    localparam logic [SETTLE_BITS-1:0]  SETTLE_ZERO = {SETTLE_BITS{1'b0}};
    localparam logic [SETTLE_BITS-1:0]  SETTLE_ONE  = SETTLE_BITS'(1);
    // A cold start holds SETTLE one cycle longer than a between-window code change.
    localparam logic [SETTLE_BITS-1:0]  SETTLE_COLD = SETTLE_BITS'(SETTLE_CYCLES);
    localparam logic [SETTLE_BITS-1:0]  SETTLE_WARM = SETTLE_BITS'(SETTLE_CYCLES - 1);

    function automatic logic [COUNTER_BITS-1:0] sat_inc(input logic [COUNTER_BITS-1:0] value,
                                                       input logic en);
        logic [COUNTER_BITS-1:0] res;
        if (en && (value != CNT_MAX)) res = value + CNT_ONE;
        else                          res = value;
        return res;
    endfunction

    state_t                  state_r, state_next_s;
    logic                    hi_meta_r, hi_sync_r, lo_meta_r, lo_sync_r;
    logic [SETTLE_BITS-1:0]  settle_cnt_r;
    logic [COUNTER_BITS-1:0] win_cnt_r, wk_hi_r, wk_lo_r, wk_z_r, wk_edges_r;
    logic                    prev_hi_r;
    logic [4:0]              dac1_r, dac2_r;
    logic                    busy_r, valid_r, overrun_r;
    logic [COUNTER_BITS-1:0] count_hi_r, count_lo_r, count_z_r, count_edges_r;
    logic                    cls_hi_s, cls_lo_s, cls_z_s, edge_s;
    logic                    codes_same_s, enter_measure_s, latch_s;

    assign cls_hi_s     = hi_sync_r;
    assign cls_lo_s     = lo_sync_r & ~hi_sync_r;
    assign cls_z_s      = ~hi_sync_r & ~lo_sync_r;
    assign edge_s       = cls_hi_s & ~prev_hi_r;
    assign codes_same_s = (bus.dac1_code_in == dac1_r) && (bus.dac2_code_in == dac2_r);

    // Next-state decode plus window-start and result-latch strobes
    always_comb begin
        state_next_s    = state_r;
        enter_measure_s = 1'b0;
        latch_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) state_next_s = ST_SETTLE;
                else           state_next_s = ST_IDLE;
            end
            ST_SETTLE: begin
                if (settle_cnt_r == SETTLE_ZERO) begin
                    state_next_s    = ST_MEASURE;
                    enter_measure_s = 1'b1;
                end else begin
                    state_next_s = ST_SETTLE;
                end
            end
            ST_MEASURE: begin
                if (win_cnt_r == WIN_LAST) state_next_s = ST_DONE;
                else                       state_next_s = ST_MEASURE;
            end
            ST_DONE: begin
                latch_s = 1'b1;
                if (!bus.continuous) begin
                    state_next_s = ST_IDLE;
                end else if (codes_same_s) begin
                    state_next_s    = ST_MEASURE;
                    enter_measure_s = 1'b1;
                end else begin
                    state_next_s = ST_SETTLE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_r <= ST_IDLE;
        else       state_r <= state_next_s;
    end

    // Two-flop synchronizers for the asynchronous comparator outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_meta_r <= 1'b0;
            hi_sync_r <= 1'b0;
            lo_meta_r <= 1'b0;
            lo_sync_r <= 1'b0;
        end else begin
            hi_meta_r <= comp_out_hi;
            hi_sync_r <= hi_meta_r;
            lo_meta_r <= comp_out_lo;
            lo_sync_r <= lo_meta_r;
        end
    end

    // DAC code latch points and settle countdown
    always_ff @(posedge clk) begin
        if (reset) begin
            dac1_r       <= 5'd0;
            dac2_r       <= 5'd0;
            settle_cnt_r <= SETTLE_ZERO;
        end else if ((state_r == ST_IDLE) && bus.start) begin
            dac1_r       <= bus.dac1_code_in;
            dac2_r       <= bus.dac2_code_in;
            settle_cnt_r <= SETTLE_COLD;
        end else if ((state_r == ST_DONE) && bus.continuous) begin
            dac1_r       <= bus.dac1_code_in;
            dac2_r       <= bus.dac2_code_in;
            settle_cnt_r <= SETTLE_WARM;
        end else if ((state_r == ST_SETTLE) && (settle_cnt_r != SETTLE_ZERO)) begin
            settle_cnt_r <= settle_cnt_r - SETTLE_ONE;
        end
    end

    // Working counters: cleared on window entry, one sample per MEASURE cycle
    always_ff @(posedge clk) begin
        if (reset || enter_measure_s) begin
            win_cnt_r  <= CNT_ZERO;
            wk_hi_r    <= CNT_ZERO;
            wk_lo_r    <= CNT_ZERO;
            wk_z_r     <= CNT_ZERO;
            wk_edges_r <= CNT_ZERO;
            prev_hi_r  <= 1'b0;
        end else if (state_r == ST_MEASURE) begin
            win_cnt_r  <= sat_inc(win_cnt_r, 1'b1);
            wk_hi_r    <= sat_inc(wk_hi_r, cls_hi_s);
            wk_lo_r    <= sat_inc(wk_lo_r, cls_lo_s);
            wk_z_r     <= sat_inc(wk_z_r, cls_z_s);
            wk_edges_r <= sat_inc(wk_edges_r, edge_s);
            prev_hi_r  <= cls_hi_s;
        end
    end

    // Result latch, valid/ack handshake and overrun; a latch beats a coincident ack
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r        <= 1'b0;
            valid_r       <= 1'b0;
            overrun_r     <= 1'b0;
            count_hi_r    <= CNT_ZERO;
            count_lo_r    <= CNT_ZERO;
            count_z_r     <= CNT_ZERO;
            count_edges_r <= CNT_ZERO;
        end else begin
            busy_r <= (state_next_s != ST_IDLE);
            if (latch_s) begin
                count_hi_r    <= wk_hi_r;
                count_lo_r    <= wk_lo_r;
                count_z_r     <= wk_z_r;
                count_edges_r <= wk_edges_r;
                valid_r       <= 1'b1;
                if (valid_r && !bus.result_ack) overrun_r <= 1'b1;
                else if (bus.result_ack)        overrun_r <= 1'b0;
            end else if (valid_r && bus.result_ack) begin
                valid_r   <= 1'b0;
                overrun_r <= 1'b0;
            end
        end
    end

    assign bus.dac1_code    = dac1_r;
    assign bus.dac2_code    = dac2_r;
    assign bus.busy         = busy_r;
    assign bus.result_valid = valid_r;
    assign bus.overrun      = overrun_r;
    assign bus.count_hi     = count_hi_r;
    assign bus.count_lo     = count_lo_r;
    assign bus.count_z      = count_z_r;
    assign bus.count_edges  = count_edges_r;
endmodule
